// File: rtl/filt_fir_mac_seq.sv
// Single-MAC FIR sequencer: sample write, tap stepping, accumulator strobes.
// Optional sticky overrun flag: define FILT_FIR_MAC_SEQ_OVR_EN.
module filt_fir_mac_seq #(
  parameter int gp_coeff_length = 16,
  parameter int gp_addr_width   = $clog2(gp_coeff_length)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_an,
  input  logic                     i_ena,
  input  logic                     i_data_vld,
  input  logic                     i_ovr_clr,
  output logic                     o_data_rdy,
  output logic                     o_smp_wr,
  output logic [gp_addr_width-1:0] o_smp_waddr,
  output logic [gp_addr_width-1:0] o_smp_raddr,
  output logic [gp_addr_width-1:0] o_coeff_addr,
  output logic                     o_acc_clr,
  output logic                     o_acc_en,
  output logic                     o_oup_vld,
  output logic                     o_ovr
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RUN,
    DONE
  } state_t;

  localparam logic [gp_addr_width-1:0] LAST =
    gp_addr_width'(gp_coeff_length - 1);

  state_t                   state;
  logic [gp_addr_width-1:0] wptr;

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state        <= IDLE;
      wptr         <= '0;
      o_data_rdy   <= 1'b1;
      o_smp_wr     <= 1'b0;
      o_smp_waddr  <= '0;
      o_smp_raddr  <= '0;
      o_coeff_addr <= '0;
      o_acc_clr    <= 1'b0;
      o_acc_en     <= 1'b0;
      o_oup_vld    <= 1'b0;
    end else if (!i_ena) begin
      o_smp_wr  <= 1'b0;
      o_acc_clr <= 1'b0;
      o_acc_en  <= 1'b0;
      o_oup_vld <= 1'b0;
    end else begin
      o_smp_wr  <= 1'b0;
      o_acc_clr <= 1'b0;
      o_acc_en  <= 1'b0;
      o_oup_vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_data_vld) begin
            state       <= WR;
            o_data_rdy  <= 1'b0;
            o_smp_wr    <= 1'b1;
            o_smp_waddr <= wptr;
          end
        end
        WR: begin
          state        <= RUN;
          o_coeff_addr <= '0;
          o_smp_raddr  <= wptr;
          o_acc_en     <= 1'b1;
          o_acc_clr    <= 1'b1;
        end
        RUN: begin
          if (o_coeff_addr == LAST) begin
            state     <= DONE;
            o_oup_vld <= 1'b1;
          end else begin
            o_coeff_addr <= o_coeff_addr + 1'b1;
            // read pointer walks back through older samples, wrapping at L
            o_smp_raddr  <= (o_smp_raddr == '0) ? LAST
                                                : o_smp_raddr - 1'b1;
            o_acc_en     <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          o_data_rdy <= 1'b1;
          wptr       <= (wptr == LAST) ? '0 : wptr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILT_FIR_MAC_SEQ_OVR_EN
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      o_ovr <= 1'b0;
    end else if (i_ena) begin
      if (i_data_vld && !o_data_rdy) begin
        o_ovr <= 1'b1;
      end else if (i_ovr_clr) begin
        o_ovr <= 1'b0;
      end
    end
  end
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = i_ovr_clr;
  assign o_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_filt_fir_mac_seq.sv
// Bench for filt_fir_mac_seq: L=16 and L=5 instances on shared stimulus,
// directed vectors plus random traffic against a frame-phase model.
module tb_filt_fir_mac_seq;

`ifdef FILT_FIR_MAC_SEQ_OVR_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic clk, rst_n, vld, ena, clr;

  logic       rdy16, wr16, clr16, en16, vld16, ovr16;
  logic [3:0] wa16, ra16, ca16;
  logic       rdy5, wr5, clr5, en5, vld5, ovr5;
  logic [2:0] wa5, ra5, ca5;

  filt_fir_mac_seq #(.gp_coeff_length(16)) u16 (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena),
    .i_data_vld(vld), .i_ovr_clr(clr),
    .o_data_rdy(rdy16), .o_smp_wr(wr16),
    .o_smp_waddr(wa16), .o_smp_raddr(ra16),
    .o_coeff_addr(ca16), .o_acc_clr(clr16),
    .o_acc_en(en16), .o_oup_vld(vld16), .o_ovr(ovr16)
  );

  filt_fir_mac_seq #(.gp_coeff_length(5)) u5 (
    .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena),
    .i_data_vld(vld), .i_ovr_clr(clr),
    .o_data_rdy(rdy5), .o_smp_wr(wr5),
    .o_smp_waddr(wa5), .o_smp_raddr(ra5),
    .o_coeff_addr(ca5), .o_acc_clr(clr5),
    .o_acc_en(en5), .o_oup_vld(vld5), .o_ovr(ovr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic logic [17:0] pk(
    logic r, logic w, logic [3:0] wa, logic [3:0] ra, logic [3:0] ca,
    logic c, logic e, logic v, logic o);
    return {r, w, wa, ra, ca, c, e, v, o};
  endfunction

  // p: -1 idle, 0 write, 1..L tap p-1, L+1 result ready
  typedef struct {
    int p; int wptr; int waddr; int raddr; int caddr;
    bit ovr; bit rdy; bit wr; bit clr; bit en; bit vld;
  } mdl_t;

  mdl_t m16, m5;

  function automatic mdl_t mreset();
    mdl_t n;
    n.p = -1; n.wptr = 0; n.waddr = 0; n.raddr = 0; n.caddr = 0;
    n.ovr = 0; n.rdy = 1; n.wr = 0; n.clr = 0; n.en = 0; n.vld = 0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t s, int L, logic v, logic e,
                                logic c);
    mdl_t n = s;
    n.wr = 0; n.clr = 0; n.en = 0; n.vld = 0;
    if (!e) return n;
    if (OVR_EXP) begin
      if (v && !s.rdy) n.ovr = 1;
      else if (c) n.ovr = 0;
    end
    if (s.p == L + 1) begin
      n.p = -1;
      n.wptr = (s.wptr + 1) % L;
    end else if (s.p >= 0) begin
      n.p = s.p + 1;
    end else if (v) begin
      n.p = 0;
    end
    n.rdy = (n.p < 0);
    n.wr  = (n.p == 0);
    n.en  = (n.p >= 1 && n.p <= L);
    n.clr = (n.p == 1);
    n.vld = (n.p == L + 1);
    if (n.wr) n.waddr = n.wptr;
    if (n.en) begin
      n.caddr = n.p - 1;
      n.raddr = (n.wptr - (n.p - 1) + L) % L;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16 = mreset();
      m5  = mreset();
    end else begin
      m16 = step(m16, 16, vld, ena, clr);
      m5  = step(m5, 5, vld, ena, clr);
    end
  end

  int wr16_cnt = 0;
  int vld16_cnt = 0;

  always @(negedge clk) begin
    chk($sformatf("model16 t=%0t", $time),
        32'(pk(rdy16, wr16, wa16, ra16, ca16, clr16, en16, vld16, ovr16)),
        32'(pk(m16.rdy, m16.wr, 4'(m16.waddr), 4'(m16.raddr),
               4'(m16.caddr), m16.clr, m16.en, m16.vld, m16.ovr)));
    chk($sformatf("model5 t=%0t", $time),
        32'(pk(rdy5, wr5, {1'b0, wa5}, {1'b0, ra5}, {1'b0, ca5},
               clr5, en5, vld5, ovr5)),
        32'(pk(m5.rdy, m5.wr, 4'(m5.waddr), 4'(m5.raddr),
               4'(m5.caddr), m5.clr, m5.en, m5.vld, m5.ovr)));
    if (wr16 === 1'b1) wr16_cnt++;
    if (vld16 === 1'b1) vld16_cnt++;
  end

  typedef struct {
    logic vld; logic ena;
    logic wr; logic [3:0] wa; logic [3:0] ra; logic [3:0] ca;
    logic clr; logic en; logic ov; logic rdy;
  } vec_t;

  vec_t tbl[19];

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    vld = 1'b0; ena = 1'b1; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rdy16 && rdy5) break;
    end
    chk("idle_timeout", 32'(c < 60), 1);
  endtask

  initial begin
    int q_wa[$];
    int q_ra[$];
    int frames, bw, bv, c;
    logic [17:0] rstv;

    rst_n = 1'b1; vld = 1'b0; ena = 1'b1; clr = 1'b0;
    rstv = pk(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 19; r++) begin
      tbl[r] = '{vld: 0, ena: 1, wr: 0, wa: 0, ra: 0, ca: 0,
                 clr: 0, en: 0, ov: 0, rdy: 0};
      if (r >= 1 && r <= 16) begin
        tbl[r].ca  = 4'(r - 1);
        tbl[r].ra  = 4'((16 - (r - 1)) % 16);
        tbl[r].en  = 1;
        tbl[r].clr = (r == 1);
      end
      if (r >= 17) begin
        tbl[r].ca = 4'd15;
        tbl[r].ra = 4'd1;
      end
    end
    tbl[0].wr  = 1;
    tbl[17].ov = 1;
    tbl[18].rdy = 1;

    // reset values while reset is held
    #1 rst_n = 1'b0;
    #3;
    chk("rst16", 32'(pk(rdy16, wr16, wa16, ra16, ca16, clr16, en16,
                        vld16, ovr16)), 32'(rstv));
    chk("rst5", 32'(pk(rdy5, wr5, {1'b0, wa5}, {1'b0, ra5},
                       {1'b0, ca5}, clr5, en5, vld5, ovr5)), 32'(rstv));
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // single frame, L=16, table driven
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    for (int r = 0; r < 19; r++) begin
      chk($sformatf("vec[%0d]", r),
          32'({wr16, wa16, ra16, ca16, clr16, en16, vld16, rdy16}),
          32'({tbl[r].wr, tbl[r].wa, tbl[r].ra, tbl[r].ca,
               tbl[r].clr, tbl[r].en, tbl[r].ov, tbl[r].rdy}));
      vld = tbl[r].vld;
      ena = tbl[r].ena;
      @(negedge clk);
    end

    // L=5 back-to-back frames, wrap of write/read pointers
    do_reset();
    frames = 0;
    vld = 1'b1;
    for (int k = 0; k < 200 && frames < 6; k++) begin
      @(negedge clk);
      if (en5 && frames == 3) q_ra.push_back(int'(ra5));
      if (wr5) begin
        q_wa.push_back(int'(wa5));
        frames++;
        if (frames == 6) vld = 1'b0;
      end
    end
    vld = 1'b0;
    chk("l5_frames", 32'(frames), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("l5_waddr[%0d]", i),
          32'((i < q_wa.size()) ? q_wa[i] : -1), 32'(i % 5));
    chk("l5_rd_cnt", 32'(q_ra.size()), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("l5_raddr[%0d]", i),
          32'((i < q_ra.size()) ? q_ra[i] : -1), 32'((2 - i + 5) % 5));

    // busy drop, overrun set/clear, set wins over clear
    do_reset();
    bw = wr16_cnt; bv = vld16_cnt;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (4) @(negedge clk);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    chk("ovr_set", 32'(ovr16), 32'(OVR_EXP));
    repeat (4) @(negedge clk);
    chk("ovr_hold", 32'(ovr16), 32'(OVR_EXP));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr", 32'(ovr16), 0);
    vld = 1'b1; clr = 1'b1;
    @(negedge clk);
    vld = 1'b0; clr = 1'b0;
    chk("ovr_set_wins", 32'(ovr16), 32'(OVR_EXP));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr2", 32'(ovr16), 0);
    wait_idle();
    chk("busy_wr_cnt", 32'(wr16_cnt - bw), 1);
    chk("busy_oup_cnt", 32'(vld16_cnt - bv), 1);

    // 7-cycle enable stall inside RUN
    do_reset();
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_stall", 32'({en16, ca16}), 32'({1'b1, 4'd2}));
    ena = 1'b0;
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      chk($sformatf("stall[%0d]", s),
          32'({en16, clr16, wr16, vld16, ca16, ra16}),
          32'({4'b0, 4'd2, 4'd14}));
    end
    ena = 1'b1;
    @(negedge clk);
    chk("resume", 32'({en16, ca16, ra16}), 32'({1'b1, 4'd3, 4'd13}));
    for (c = 13; c < 31; c++) begin
      @(negedge clk);
      if (vld16) break;
    end
    chk("stall_oup_cycle", 32'(c), 25);
    wait_idle();

    // reset mid-frame at tap 8, after one completed frame
    do_reset();
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    wait_idle();
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_tap", 32'(ca16), 8);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst16", 32'(pk(rdy16, wr16, wa16, ra16, ca16, clr16, en16,
                           vld16, ovr16)), 32'(rstv));
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    bv = vld16_cnt;
    repeat (25) @(negedge clk);
    chk("no_oup_after_rst", 32'(vld16_cnt - bv), 0);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    chk("waddr_after_rst", 32'({wr16, wa16}), 32'({1'b1, 4'd0}));
    wait_idle();

    // random traffic, checked every cycle against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      vld = ($urandom_range(0, 99) < 30);
      ena = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 5);
    end
    vld = 1'b0; ena = 1'b1; clr = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/filt_fir_mac_seq.md
# filt_fir_mac_seq

Sequencer for a time-shared, single-MAC FIR datapath. One input sample is accepted per frame and written into an external circular sample RAM. The block then steps the coefficient and sample read addresses through all taps, driving the accumulator clear/enable strobes, and flags when the accumulator holds the final output. It sits between the sample source and the external sample RAM / coefficient ROM / MAC, replacing the fully parallel filter where area matters.

## Interface
- gp_coeff_length, 16, number of taps L; minimum 2; need not be a power of two
- gp_addr_width, $clog2(gp_coeff_length), width of every address output
- i_clk  in  1  clock; all logic on rising edge
- i_rst_an  in  1  asynchronous active-low reset
- i_ena  in  1  global clock enable; low freezes all state
- i_data_vld  in  1  new input sample present on the external sample bus this cycle
- i_ovr_clr  in  1  clears o_ovr
- o_data_rdy  out  1  sequencer idle; a sample is accepted when i_data_vld & o_data_rdy & i_ena
- o_smp_wr  out  1  sample RAM write strobe
- o_smp_waddr  out  gp_addr_width  sample RAM write address
- o_smp_raddr  out  gp_addr_width  sample RAM read address
- o_coeff_addr  out  gp_addr_width  coefficient ROM address (tap index k)
- o_acc_clr  out  1  accumulator loads the product instead of adding it (tap 0)
- o_acc_en  out  1  accumulator update enable
- o_oup_vld  out  1  one-cycle pulse: accumulator holds the final result
- o_ovr  out  1  sticky overrun flag (see Configuration)

## Operation
- All outputs are registered.
- Reset values:
  - o_data_rdy=1
  - o_smp_wr, o_acc_clr, o_acc_en, o_oup_vld, o_ovr = 0
  - all addresses = 0
  - write pointer wptr=0
  - state IDLE
- FSM states: IDLE, WR, RUN, DONE.
  - IDLE: o_data_rdy=1. On accept, go to WR.
  - WR, one cycle: o_smp_wr=1, o_smp_waddr=wptr, o_data_rdy=0. Go to RUN.
  - RUN, L cycles, tap index k=0..L-1:
    - o_coeff_addr=k
    - o_smp_raddr=(wptr−k) mod L
    - o_acc_en=1
    - o_acc_clr=1 only at k=0
    - after k=L−1, go to DONE.
  - DONE, one cycle: o_oup_vld=1, wptr←(wptr==L−1)?0:wptr+1. Go to IDLE.
- Read-address wrap: the read pointer counts down from wptr and wraps 0→L−1. Do not compute it with a power-of-two mask.
- The external datapath delays o_acc_clr and o_acc_en by its own RAM/ROM read latency. This block assumes no latency.
- i_ena=0:
  - FSM, counters and wptr hold.
  - Strobes o_smp_wr, o_acc_en, o_acc_clr, o_oup_vld are driven 0.
  - Addresses hold.
  - Frames resume exactly where they left off when i_ena returns to 1; the tap in progress is reissued.
- i_data_vld while o_data_rdy=0 (busy): the sample is dropped and the frame in progress is unaffected.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded and produces no o_oup_vld.

## Timing
- Accept at edge T (i_data_vld & o_data_rdy & i_ena sampled high).
  - T+1: WR cycle, o_smp_wr=1.
  - T+2 … T+1+L: RUN.
  - T+2+L: o_oup_vld=1.
  - T+3+L: o_data_rdy=1.
- Frame period is L+3 cycles with i_ena held high. Maximum input rate is one sample per L+3 cycles.
- o_data_rdy falls at T+1, the same cycle as o_smp_wr. A second i_data_vld at T+1 is therefore a busy-case sample.
- o_oup_vld and o_data_rdy are never high in the same cycle.

## Configuration
- FILT_FIR_MAC_SEQ_OVR_EN defined:
  - o_ovr is set on any cycle with i_data_vld=1, o_data_rdy=0, i_ena=1.
  - It stays set until i_ovr_clr=1.
  - If set and clear occur in the same cycle, set wins.
- FILT_FIR_MAC_SEQ_OVR_EN undefined:
  - o_ovr is constant 0 and i_ovr_clr is ignored.
  - The port list is unchanged; no overrun logic is synthesized.

## Test plan
- Single frame, L=16, one i_data_vld after reset:
  - o_smp_wr one cycle later, with waddr=0.
  - 16 RUN cycles: coeff_addr 0..15, raddr 0,15,14,…,1, acc_clr only on the first.
  - o_oup_vld at T+18; o_data_rdy back at T+19.
- Non-power-of-two wrap, L=5, six back-to-back frames:
  - waddr sequence 0,1,2,3,4,0.
  - Frame with wptr=2: raddr 2,1,0,4,3.
- Busy drop, L=16: second i_data_vld at T+5.
  - With macro: no extra o_smp_wr, o_ovr=1 at T+6 and held; i_ovr_clr pulse clears it.
  - Without macro: same drop, o_ovr stays 0.
- i_ena low for 7 cycles during RUN at k=3:
  - All strobes 0 and addresses frozen during the stall.
  - Resumes with k=3.
  - o_oup_vld delayed by exactly 7 cycles.
- Reset pulse at RUN k=8: all outputs at reset values within the reset, no o_oup_vld, next accepted sample written to waddr=0.
- Simultaneous set and clear with macro: i_ovr_clr=1 in the same cycle as an overrun → o_ovr remains 1.
